// File: rtl/sm_mult_ctrl.sv
// Sequential sign-magnitude multiplier: a three-process FSM sequences a shift-add
// datapath (mcand, carry/acc/mq shift chain, down-counter) into a registered 2N-bit product.
module sm_mult_ctrl #(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           op_sel,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [N-2:0]     r_mcand;
  logic [N-2:0]     r_acc;
  logic [N-2:0]     r_mq;
  logic             r_carry;
  logic             r_sign;
  logic [CW-1:0]    r_count;
  logic [2*N-1:0]   r_product;

  logic [N-1:0]     w_sum;
  logic [2*N-2:0]   w_shift;
  logic             w_last;

  // The adder carry becomes the acc MSB after the shift, so no overflow is lost.
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_mcand};
  assign w_shift = {1'b0, r_carry, r_acc, r_mq[N-2:1]};
  assign w_last  = (r_count == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = S_ADD;
      S_ADD:   w_next = S_SHIFT;
      S_SHIFT: w_next = w_last ? S_DONE : S_ADD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    op_sel = (r_state == S_LOAD);
    busy   = (r_state == S_LOAD) || (r_state == S_ADD) || (r_state == S_SHIFT);
    done   = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mq      <= '0;
      r_carry   <= 1'b0;
      r_sign    <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_mcand <= a[N-2:0];
          r_mq    <= b[N-2:0];
          r_acc   <= '0;
          r_carry <= 1'b0;
          r_sign  <= a[N-1] ^ b[N-1];
          r_count <= CW'(N-1);
        end
        S_ADD: begin
          if (r_mq[0]) {r_carry, r_acc} <= w_sum;
        end
        S_SHIFT: begin
          {r_carry, r_acc, r_mq} <= w_shift;
          r_count <= r_count - CW'(1);
          // Capture on entry to DONE; a zero magnitude is forced positive.
          if (w_last) begin
            r_product <= {r_sign & (|w_shift[2*N-3:0]), 1'b0, w_shift[2*N-3:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_sm_mult_ctrl.sv
// Directed bench for sm_mult_ctrl (N=6): latency, sign handling, carry path,
// operand capture, async reset and back-to-back throughput.
module tb_sm_mult_ctrl;

  localparam int N = 6;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           op_sel;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int overlap  = 0;

  sm_mult_ctrl #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .op_sel  (op_sel),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy && done) overlap <= overlap + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation: optional mid-op start pulse and optional operand change from ADD on.
  task automatic do_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [2*N-1:0] exp, input bit pulse, input bit mut);
    int cycles;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    check({tag, "_load_opsel"}, op_sel, 1);
    check({tag, "_load_busy"}, busy, 1);
    while (!done && cycles < 40) begin
      start = pulse && (cycles == 5);
      if (mut && cycles == 2) begin
        a = 6'b0_11111;
        b = 6'b0_11111;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, cycles, 12);
    check({tag, "_busy_in_done"}, busy, 0);
    check({tag, "_product"}, product, exp);
    $display("op %s a=%b b=%b product=0x%03h cycles=%0d", tag, av, bv, product, cycles);
    if (pulse) begin
      @(negedge clk);
      check({tag, "_no_queue1"}, busy, 0);
      @(negedge clk);
      check({tag, "_no_queue2"}, busy, 0);
    end
  endtask

  initial begin
    int d[3];
    int nd;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_product", product, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_opsel", op_sel, 0);
    rst_n = 1'b1;

    do_op("pos3_neg5", 6'b0_00011, 6'b1_00101, 12'h80F, 1'b1, 1'b0);
    do_op("neg31_neg31", 6'b1_11111, 6'b1_11111, 12'h3C1, 1'b0, 1'b0);
    do_op("negzero_pos7", 6'b1_00000, 6'b0_00111, 12'h000, 1'b0, 1'b0);
    do_op("neg5_pos3", 6'b1_00101, 6'b0_00011, 12'h80F, 1'b0, 1'b0);
    do_op("poszero_neg31", 6'b0_00000, 6'b1_11111, 12'h000, 1'b0, 1'b0);
    do_op("late_change", 6'b0_00010, 6'b0_00010, 12'h004, 1'b0, 1'b1);
    do_op("pos31_neg1", 6'b0_11111, 6'b1_00001, 12'h81F, 1'b0, 1'b0);

    // Async reset while in SHIFT (third cycle after start sampling).
    @(negedge clk);
    a = 6'b0_00111; b = 6'b0_00111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_product", product, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_busy", busy, 0);
    check("postrst_done", done, 0);
    check("postrst_product", product, 0);

    // Start held high: one result per 13 cycles.
    a = 6'b0_00011; b = 6'b0_00101; start = 1'b1;
    nd = 0;
    for (int i = 0; i < 60 && nd < 3; i++) begin
      @(negedge clk);
      if (done) begin
        d[nd] = cyc;
        nd++;
      end
    end
    start = 1'b0;
    check("hold_ndone", nd, 3);
    if (nd == 3) begin
      check("hold_gap1", d[1] - d[0], 13);
      check("hold_gap2", d[2] - d[1], 13);
    end
    check("hold_product", product, 12'h00F);
    $display("op hold_start done_count=%0d product=0x%03h", nd, product);
    @(negedge clk);
    check("busy_done_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
